// File: rtl/fir_bridge_pkg.sv
// Shared definitions for the FIR Wishbone/AXI-Stream bridges: register
// addresses and the Wishbone handshake FSM encoding.
package fir_bridge_pkg;

  localparam logic [7:0] ADR_DATA_IN   = 8'h80;
  localparam logic [7:0] ADR_FRAME_LEN = 8'h88;
  localparam logic [7:0] ADR_STATUS    = 8'h90;
  localparam logic [7:0] ADR_IDX       = 8'h94;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned IDX_W     = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    ACK        = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; head entry is presented
// combinationally from storage flops.
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign push_ok_c = push & ~full;
  assign pop_ok_c  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    count_d  = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/wb_axis_in_bridge.sv
// Wishbone-to-AXI-Stream ingress bridge: firmware pushes samples over
// Wishbone, they leave as an AXIS master stream with per-frame tlast tagging.
module wb_axis_in_bridge
  import fir_bridge_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready
);

  localparam int unsigned ENTRY_W = pDATA_WIDTH + 1;

  bridge_state_e          state_q, state_d;
  logic                   ack_q, ack_d;
  logic [WB_DATA_W-1:0]   dat_q, dat_d;
  logic [IDX_W-1:0]       frame_len_q, frame_len_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic [7:0]             adr_c;
  logic                   req_c;
  logic                   wr_data_hit_c;
  logic                   access_c;
  logic                   push_c;
  logic                   pop_c;
  logic                   tag_last_c;
  logic [WB_DATA_W-1:0]   rdata_c;
  logic [ENTRY_W-1:0]     head_c;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic                   unused_ok;

  assign unused_ok     = ^{wbs_sel_i, wbs_adr_i[31:8]};
  assign adr_c         = wbs_adr_i[7:0];
  assign req_c         = wbs_cyc_i & wbs_stb_i;
  assign wr_data_hit_c = wbs_we_i & (adr_c == ADR_DATA_IN);

  // Register read mux; unmapped addresses read as zero.
  always_comb begin
    rdata_c = '0;
    case (adr_c)
      ADR_FRAME_LEN: rdata_c = WB_DATA_W'(frame_len_q);
      ADR_STATUS: begin
        rdata_c[0]         = fifo_empty;
        rdata_c[1]         = fifo_full;
        rdata_c[CNT_W+7:8] = fifo_count;
      end
      ADR_IDX:       rdata_c = WB_DATA_W'(idx_q);
      default:       rdata_c = '0;
    endcase
  end

  // Handshake FSM; every register side effect lands on the edge entering ACK.
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    dat_d       = '0;
    frame_len_d = frame_len_q;
    idx_d       = idx_q;
    access_c    = 1'b0;
    push_c      = 1'b0;
    tag_last_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          if (wr_data_hit_c && fifo_full) begin
            state_d = WAIT_SPACE;
          end else begin
            state_d  = ACK;
            access_c = 1'b1;
          end
        end
      end
      WAIT_SPACE: begin
        if (!fifo_full) begin
          state_d  = ACK;
          access_c = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (access_c) begin
      ack_d = 1'b1;
      if (wbs_we_i) begin
        if (adr_c == ADR_DATA_IN) begin
          push_c = 1'b1;
          if ((frame_len_q != '0) && (idx_q == frame_len_q - IDX_W'(1))) begin
            tag_last_c = 1'b1;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (adr_c == ADR_FRAME_LEN) begin
          frame_len_d = wbs_dat_i[IDX_W-1:0];
          idx_d       = '0;
        end
      end else begin
        dat_d = rdata_c;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      frame_len_q <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      frame_len_q <= frame_len_d;
      idx_q       <= idx_d;
    end
  end

  assign pop_c = ~fifo_empty & ss_tready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .push      (push_c),
    .push_data ({tag_last_c, wbs_dat_i[pDATA_WIDTH-1:0]}),
    .pop       (pop_c),
    .head_data (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign ss_tvalid = ~fifo_empty;
  assign ss_tdata  = head_c[pDATA_WIDTH-1:0];
  assign ss_tlast  = head_c[pDATA_WIDTH];

endmodule
